// File: rtl/etapa_ex_multiciclo.sv
// MIPS32 execute stage: single-cycle ALU, branch target and destination select,
// plus iterative unsigned MULTU/DIVU over HI/LO that stalls the upstream pipeline.
module etapa_ex_multiciclo #(
    parameter int unsigned ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] sumador_ID_EX,
    input  logic [31:0] Read_Data_1_ID_EX,
    input  logic [31:0] Read_Data_2_ID_EX,
    input  logic [31:0] Instruccion_Extendida_ID_EX,
    input  logic [4:0]  Instruccion_RD_ID_EX,
    input  logic [4:0]  Instruccion_RT_ID_EX,
    input  logic        RegDst_ID_EX,
    input  logic        Branch_ID_EX,
    input  logic        MemToRead_ID_EX,
    input  logic        MemToWrite_ID_EX,
    input  logic        ALUSrc_ID_EX,
    input  logic        RegWrite_ID_EX,
    input  logic        MemToReg_ID_EX,
    input  logic [2:0]  ALUOp_ID_EX,
    output logic        stall,
    output logic [31:0] ALU_Result_EX_MEM,
    output logic [31:0] Branch_Target_EX_MEM,
    output logic        Zero_EX_MEM,
    output logic [31:0] Read_Data_2_EX_MEM,
    output logic [4:0]  Write_Reg_EX_MEM,
    output logic        Branch_EX_MEM,
    output logic        MemToRead_EX_MEM,
    output logic        MemToWrite_EX_MEM,
    output logic        RegWrite_EX_MEM,
    output logic        MemToReg_EX_MEM
);
    localparam int unsigned CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MFHI, OP_MFLO, OP_MULTU, OP_DIVU
    } alu_op_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   work_q, work_d;
    logic [31:0]   opb_q, opb_d;
    logic          is_div_q, is_div_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;

    logic [31:0] alu_result_q, alu_result_d, branch_target_q, branch_target_d;
    logic [31:0] read_data_2_q, read_data_2_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic        zero_q, zero_d, branch_q, branch_d, mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d, reg_write_q, reg_write_d, mem_to_reg_q, mem_to_reg_d;

    alu_op_t     op;
    logic [31:0] operand_b, alu_res;
    logic        is_muldiv, bubble, stall_c;
    logic [32:0] mul_sum, div_sh;
    logic [33:0] div_diff;
    logic [63:0] mul_next, div_next;

    always_comb begin
        op = OP_ADD;
        unique case (ALUOp_ID_EX)
            3'b001: op = OP_SUB;
            3'b011: op = OP_AND;
            3'b100: op = OP_OR;
            3'b101: op = OP_SLT;
            3'b010: begin
                unique case (Instruccion_Extendida_ID_EX[5:0])
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b101010: op = OP_SLT;
                    6'b010000: op = OP_MFHI;
                    6'b010010: op = OP_MFLO;
                    6'b011001: op = OP_MULTU;
                    6'b011011: op = OP_DIVU;
                    default:   op = OP_ADD;
                endcase
            end
            default: op = OP_ADD;
        endcase
    end

    assign operand_b = ALUSrc_ID_EX ? Instruccion_Extendida_ID_EX : Read_Data_2_ID_EX;
    assign is_muldiv = (op == OP_MULTU) || (op == OP_DIVU);

    always_comb begin
        alu_res = Read_Data_1_ID_EX + operand_b;
        unique case (op)
            OP_SUB:  alu_res = Read_Data_1_ID_EX - operand_b;
            OP_AND:  alu_res = Read_Data_1_ID_EX & operand_b;
            OP_OR:   alu_res = Read_Data_1_ID_EX | operand_b;
            OP_SLT:  alu_res = {31'b0, $signed(Read_Data_1_ID_EX) < $signed(operand_b)};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = Read_Data_1_ID_EX + operand_b;
        endcase
    end

    // work_q holds {HI-part, LO-part}: product accumulator for MULTU,
    // {remainder, quotient} for DIVU; both finish with HI/LO in place.
    assign mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opb_q} : 33'b0);
    assign mul_next = {mul_sum, work_q[31:1]};
    assign div_sh   = {work_q[63:32], work_q[31]};
    assign div_diff = {1'b0, div_sh} - {2'b0, opb_q};
    assign div_next = div_diff[33] ? {div_sh[31:0], work_q[30:0], 1'b0}
                                   : {div_diff[31:0], work_q[30:0], 1'b1};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        stall_c  = 1'b0;
        bubble   = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            bubble  = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_muldiv) begin
                        stall_c  = 1'b1;
                        bubble   = 1'b1;
                        work_d   = {32'b0, Read_Data_1_ID_EX};
                        opb_d    = Read_Data_2_ID_EX;
                        is_div_d = (op == OP_DIVU);
                        cnt_d    = '0;
                        state_d  = S_BUSY;
                    end
                end
                S_BUSY: begin
                    stall_c = 1'b1;
                    bubble  = 1'b1;
                    work_d  = is_div_q ? div_next : mul_next;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) state_d = S_DONE;
                end
                S_DONE: begin
                    bubble  = 1'b1;
                    hi_d    = work_q[63:32];
                    lo_d    = work_q[31:0];
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        alu_result_d    = '0;
        branch_target_d = '0;
        read_data_2_d   = '0;
        write_reg_d     = '0;
        zero_d          = 1'b0;
        branch_d        = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        reg_write_d     = 1'b0;
        mem_to_reg_d    = 1'b0;
        if (!bubble) begin
            alu_result_d    = alu_res;
            branch_target_d = sumador_ID_EX + {Instruccion_Extendida_ID_EX[29:0], 2'b00};
            read_data_2_d   = Read_Data_2_ID_EX;
            write_reg_d     = RegDst_ID_EX ? Instruccion_RD_ID_EX : Instruccion_RT_ID_EX;
            zero_d          = (alu_res == 32'b0);
            branch_d        = Branch_ID_EX;
            mem_read_d      = MemToRead_ID_EX;
            mem_write_d     = MemToWrite_ID_EX;
            reg_write_d     = RegWrite_ID_EX;
            mem_to_reg_d    = MemToReg_ID_EX;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            work_q          <= '0;
            opb_q           <= '0;
            is_div_q        <= 1'b0;
            hi_q            <= '0;
            lo_q            <= '0;
            alu_result_q    <= '0;
            branch_target_q <= '0;
            read_data_2_q   <= '0;
            write_reg_q     <= '0;
            zero_q          <= 1'b0;
            branch_q        <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            work_q          <= work_d;
            opb_q           <= opb_d;
            is_div_q        <= is_div_d;
            hi_q            <= hi_d;
            lo_q            <= lo_d;
            alu_result_q    <= alu_result_d;
            branch_target_q <= branch_target_d;
            read_data_2_q   <= read_data_2_d;
            write_reg_q     <= write_reg_d;
            zero_q          <= zero_d;
            branch_q        <= branch_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            reg_write_q     <= reg_write_d;
            mem_to_reg_q    <= mem_to_reg_d;
        end
    end

    assign stall                = stall_c & ~reset;
    assign ALU_Result_EX_MEM    = alu_result_q;
    assign Branch_Target_EX_MEM = branch_target_q;
    assign Zero_EX_MEM          = zero_q;
    assign Read_Data_2_EX_MEM   = read_data_2_q;
    assign Write_Reg_EX_MEM     = write_reg_q;
    assign Branch_EX_MEM        = branch_q;
    assign MemToRead_EX_MEM     = mem_read_q;
    assign MemToWrite_EX_MEM    = mem_write_q;
    assign RegWrite_EX_MEM      = reg_write_q;
    assign MemToReg_EX_MEM      = mem_to_reg_q;
endmodule
